// File: rtl/cifra_iterativa.sv
// Iterative AES encryption core: one round per clock over a 128-bit state, NR = 10/12/14.
// Optional build macro CIFRA_ITERATIVA_TRAVA_CHAVE_EN latches the expanded key at accept.
module cifra_iterativa #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  entrada_valida,
    output logic                  entrada_pronta,
    input  logic [127:0]          bloco,
    input  logic [128*(NR+1)-1:0] chaveExpandida,
    input  logic                  cancela,
    output logic                  saida_valida,
    input  logic                  saida_pronta,
    output logic [127:0]          saida,
    output logic                  ocupado
);

    localparam int          KW   = 128 * (NR + 1);
    localparam logic [3:0]  NR_L = 4'(NR);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_invalido
            $error("cifra_iterativa: NR must be 10, 12 or 14");
        end
    endgenerate

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        RODADA = 2'd1,
        PRONTO = 2'd2
    } fsm_t;

    fsm_t         state_q, state_d;
    logic [127:0] estado_q, estado_d;
    logic [127:0] saida_q, saida_d;
    logic [3:0]   rodada_q, rodada_d;
    logic [KW-1:0] chave_fonte_s;
    logic [127:0] chave_rodada_s;
    logic [127:0] sb_sr_s;
    logic [127:0] mc_s;
    logic         aceita_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        e = 8'hfe;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] substitui_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i of the block is row i%4, column i/4
    function automatic logic [127:0] rotaciona_linhas(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] multiplica_colunas(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] chave_k(input logic [KW-1:0] c, input logic [3:0] k);
        int base;
        base = KW - 1 - 128 * int'(k);
        return c[base -: 128];
    endfunction

    assign entrada_pronta = (state_q == OCIOSO);
    assign ocupado        = ~entrada_pronta;
    assign aceita_s       = entrada_valida && entrada_pronta;
    assign saida_valida   = (state_q == PRONTO);
    assign saida          = saida_q;

`ifdef CIFRA_ITERATIVA_TRAVA_CHAVE_EN
    logic [KW-1:0] chave_q, chave_d;

    // Key snapshot taken at the accept edge
    always_comb begin
        chave_d = chave_q;
        if (aceita_s) begin
            chave_d = chaveExpandida;
        end else begin
            chave_d = chave_q;
        end
    end

    // Key snapshot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chave_q <= '0;
        else        chave_q <= chave_d;
    end

    assign chave_fonte_s = chave_q;
`else
    assign chave_fonte_s = chaveExpandida;
`endif

    assign chave_rodada_s = chave_k(chave_fonte_s, rodada_q);
    assign sb_sr_s        = rotaciona_linhas(substitui_bytes(estado_q));
    assign mc_s           = multiplica_colunas(sb_sr_s);

    // Next-state logic: round sequencing, final round without MixColumns, abort
    always_comb begin
        state_d  = state_q;
        estado_d = estado_q;
        rodada_d = rodada_q;
        saida_d  = saida_q;
        case (state_q)
            OCIOSO: begin
                if (aceita_s) begin
                    estado_d = bloco ^ chave_k(chaveExpandida, 4'd0);
                    rodada_d = 4'd1;
                    state_d  = RODADA;
                end else begin
                    rodada_d = 4'd0;
                end
            end
            RODADA: begin
                if (cancela) begin
                    state_d  = OCIOSO;
                    estado_d = 128'd0;
                    rodada_d = 4'd0;
                    saida_d  = 128'd0;
                end else if (rodada_q < NR_L) begin
                    estado_d = mc_s ^ chave_rodada_s;
                    rodada_d = rodada_q + 4'd1;
                end else begin
                    estado_d = sb_sr_s ^ chave_rodada_s;
                    saida_d  = sb_sr_s ^ chave_rodada_s;
                    state_d  = PRONTO;
                end
            end
            PRONTO: begin
                if (cancela) begin
                    state_d  = OCIOSO;
                    estado_d = 128'd0;
                    rodada_d = 4'd0;
                    saida_d  = 128'd0;
                end else if (saida_pronta) begin
                    state_d  = OCIOSO;
                    rodada_d = 4'd0;
                    saida_d  = 128'd0;
                end else begin
                    state_d  = PRONTO;
                end
            end
            default: begin
                state_d  = OCIOSO;
                estado_d = 128'd0;
                rodada_d = 4'd0;
                saida_d  = 128'd0;
            end
        endcase
    end

    // State, round counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OCIOSO;
            estado_q <= 128'd0;
            rodada_q <= 4'd0;
            saida_q  <= 128'd0;
        end else begin
            state_q  <= state_d;
            estado_q <= estado_d;
            rodada_q <= rodada_d;
            saida_q  <= saida_d;
        end
    end

endmodule

// File: doc/cifra_iterativa.md
# cifra_iterativa

Iterative AES encryption core: one round per clock over a single 128-bit state register, parametrised for AES-128/192/256 round counts. Wraps the team's `substituiBytes`, `rotacionaLinhas` and `multiplicaColunas` datapath blocks with a round counter, a final-round (no MixColumns) path and valid/ready handshakes on input and output. Sits between the key-expansion block, which supplies the expanded key, and the block-mode/stream layer.

## Interface
- `NR`, 10, number of rounds; legal values 10, 12, 14; any other value is a elaboration error.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `entrada_valida`  in  1  `bloco` valid this cycle.
- `entrada_pronta`  out  1  core can accept a block.
- `bloco`  in  128  plaintext block, byte 0 at [127:120].
- `chaveExpandida`  in  128*(NR+1)  round keys; key k at [128*(NR+1)-1-128k -: 128].
- `cancela`  in  1  synchronous abort of the block in flight.
- `saida_valida`  out  1  `saida` holds a finished ciphertext.
- `saida_pronta`  in  1  consumer accepts `saida`.
- `saida`  out  128  ciphertext, same byte order as `bloco`.
- `ocupado`  out  1  high in RODADA or PRONTO.

## Operation
- FSM states: OCIOSO, RODADA, PRONTO. Reset state OCIOSO.
- `entrada_pronta` = (state == OCIOSO), combinational; `ocupado` = !entrada_pronta.
- OCIOSO: on `entrada_valida && entrada_pronta` → estado <= `bloco ^ k0`, rodada <= 1, go RODADA.
- RODADA, rodada < NR: estado <= MC(SR(SB(estado))) ^ k[rodada]; rodada += 1.
- RODADA, rodada == NR: estado <= SR(SB(estado)) ^ k[NR] (no MixColumns); go PRONTO.
- PRONTO: `saida_valida` = 1, `saida` = estado, held stable until `saida_pronta`; on `saida_pronta` go OCIOSO.
- `rodada` is 4 bits; never exceeds NR; reset 0; cleared to 0 on return to OCIOSO.
- `cancela` in RODADA or PRONTO: next state OCIOSO, rodada <= 0, estado <= 0; no output handshake. `cancela` has priority over `saida_pronta` in the same cycle. Ignored in OCIOSO (a simultaneous `entrada_valida` is accepted normally).
- `entrada_valida` outside OCIOSO is ignored; no queueing.
- `saida` reads as 0 whenever `saida_valida` is 0.

## Timing
- Reset values: estado 0, rodada 0, `saida` 0, `saida_valida` 0, `ocupado` 0, `entrada_pronta` 1 (also while `rst_n` low).
- Reset asserted mid-block: immediate return to OCIOSO, block discarded, outputs to reset values without waiting for a clock edge.
- Latency: accept at edge E0; rounds at E1..E_NR; `saida_valida` high in the cycle after E_NR (NR+1 cycles accept-to-valid).
- Output transfer on first edge with `saida_valida && saida_pronta`; `entrada_pronta` high the following cycle. Back-to-back throughput: one block per NR+2 cycles with `saida_pronta` tied high.
- One round is the critical path: SB+SR+MC+XOR in one cycle.

## Configuration
- `CIFRA_ITERATIVA_TRAVA_CHAVE_EN` defined: `chaveExpandida` is captured into an internal 128*(NR+1) register at the accept edge; round keys come from that copy, so the input may change freely after acceptance.
- Not defined: no key register; round keys are read live from `chaveExpandida`, which must stay stable from the accept edge until `saida_valida` rises. Handshake and latency identical in both builds.

## Test plan
- FIPS-197 C.1, NR=10: `bloco`=00112233445566778899aabbccddeeff, key 000102…0f expanded by bench → `saida`=69c4e0d86a7b0430d8cdb78070b4c55a, `saida_valida` exactly 11 cycles after accept.
- NR=12 and NR=14 with FIPS-197 C.2/C.3 keys, same plaintext → dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089; latency 13 and 15 cycles.
- Backpressure: `saida_pronta` low for 5 cycles after valid → `saida` stable, `entrada_pronta` stays 0, new `entrada_valida` ignored; transfer then idle next cycle.
- `cancela` at round 4 → OCIOSO next cycle, `saida_valida` never asserts; following C.1 block still yields 69c4e0d8….
- `rst_n` pulled low at round 6 → `saida_valida` 0, `entrada_pronta` 1 immediately; clean C.1 run after release.
- With `CIFRA_ITERATIVA_TRAVA_CHAVE_EN`: change `chaveExpandida` to all-ones one cycle after accept → result still 69c4e0d8…; without macro the bench only checks stable-key runs.
